// File: rtl/fishing_pkg.sv
// Shared types and geometry constants for the fishing hook/line controller.
// Positions are in 0.1-pixel units; rows are in whole pixels.
package fishing_pkg;

  localparam int POS_W = 14;
  localparam int ROW_W = 10;

  localparam logic [POS_W-1:0] HOOK_X    = 14'd2790;
  localparam logic [POS_W-1:0] TOP_V     = 14'd620;
  localparam logic [POS_W-1:0] MAX_V     = 14'd4500;
  localparam logic [POS_W-1:0] BOTTOM_V  = 14'd4800;
  localparam logic [POS_W-1:0] DROP_STEP = 14'd20;
  localparam logic [POS_W-1:0] REEL_STEP = 14'd30;
  localparam logic [POS_W-1:0] SINK_STEP = 14'd40;

  localparam logic [ROW_W-1:0] TOP_ROW      = 10'd62;
  localparam logic [ROW_W-1:0] RETRACT_STEP = 10'd3;

  localparam logic signed [7:0] SWAY_AMP = 8'sd30;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DROP    = 3'd1,
    ST_HOLD    = 3'd2,
    ST_REEL    = 3'd3,
    ST_SINK    = 3'd4,
    ST_RETRACT = 3'd5
  } hook_state_t;

endpackage

// File: rtl/hook_controller_if.sv
// Button/game-logic inputs and hook geometry outputs of the hook controller.
// master = game logic side, slave = the controller.
interface hook_controller_if;
  logic                           frame_tick;
  logic                           drop_btn;
  logic                           reel_btn;
  logic                           line_break;
  logic [fishing_pkg::POS_W-1:0]  h_position;
  logic [fishing_pkg::POS_W-1:0]  v_position;
  logic                           cut;
  logic [fishing_pkg::ROW_W-1:0]  cut_v;
  logic                           busy;
  logic                           reel_done;

  modport master (
    output frame_tick, drop_btn, reel_btn, line_break,
    input  h_position, v_position, cut, cut_v, busy, reel_done
  );

  modport slave (
    input  frame_tick, drop_btn, reel_btn, line_break,
    output h_position, v_position, cut, cut_v, busy, reel_done
  );
endinterface

// File: rtl/div_by_10.sv
// Combinational divide-by-10 turning a 0.1-px position into a pixel row.
// Shared with the colour path; results above the row width are truncated.
module div_by_10
  import fishing_pkg::*;
(
  input  logic [POS_W-1:0] dividend,
  output logic [ROW_W-1:0] quotient
);

  assign quotient = ROW_W'(dividend / POS_W'(10));

endmodule

// File: rtl/hook_controller.sv
// Fishing-line cast/reel/break state machine producing hook and line geometry.
// Define HOOK_SWAY_EN to add a triangular horizontal sway in HOLD and SINK.
module hook_controller
  import fishing_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  hook_controller_if.slave hook
);

  hook_state_t      state_reg;
  logic [POS_W-1:0] v_reg;
  logic             cut_reg;
  logic [ROW_W-1:0] cut_v_reg;
  logic             busy_reg;
  logic             reel_done_reg;
  logic [ROW_W-1:0] v_row;

  logic             break_take;
  logic             tick_take;
  logic [POS_W-1:0] drop_sum;
  logic [POS_W-1:0] sink_sum;
  logic             drop_last;
  logic             reel_last;
  logic             sink_last;
  logic             retract_last;

  div_by_10 u_div (
    .dividend (v_reg),
    .quotient (v_row)
  );

  // A break needs no tick and pre-empts any step on the same cycle.
  assign break_take = hook.line_break &&
                      (state_reg == ST_DROP || state_reg == ST_HOLD || state_reg == ST_REEL);
  assign tick_take  = hook.frame_tick && !break_take;

  assign drop_sum     = v_reg + DROP_STEP;
  assign sink_sum     = v_reg + SINK_STEP;
  assign drop_last    = drop_sum >= MAX_V;
  assign reel_last    = v_reg <= TOP_V + REEL_STEP;
  assign sink_last    = sink_sum >= BOTTOM_V;
  assign retract_last = cut_v_reg <= TOP_ROW + RETRACT_STEP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      v_reg         <= TOP_V;
      cut_reg       <= 1'b0;
      cut_v_reg     <= TOP_ROW;
      busy_reg      <= 1'b0;
      reel_done_reg <= 1'b0;
    end else begin
      reel_done_reg <= 1'b0;
      if (break_take) begin
        cut_reg   <= 1'b1;
        cut_v_reg <= v_row;
        state_reg <= ST_SINK;
      end else if (tick_take) begin
        case (state_reg)
          ST_IDLE: begin
            if (hook.drop_btn) begin
              state_reg <= ST_DROP;
              busy_reg  <= 1'b1;
            end
          end
          ST_DROP: begin
            if (hook.reel_btn) begin
              state_reg <= ST_REEL;
            end else if (drop_last) begin
              v_reg     <= MAX_V;
              state_reg <= ST_HOLD;
            end else begin
              v_reg <= drop_sum;
            end
          end
          ST_HOLD: begin
            if (hook.reel_btn) state_reg <= ST_REEL;
          end
          ST_REEL: begin
            if (reel_last) begin
              v_reg         <= TOP_V;
              state_reg     <= ST_IDLE;
              busy_reg      <= 1'b0;
              reel_done_reg <= 1'b1;
            end else begin
              v_reg <= v_reg - REEL_STEP;
            end
          end
          ST_SINK: begin
            if (sink_last) begin
              v_reg     <= BOTTOM_V;
              state_reg <= ST_RETRACT;
            end else begin
              v_reg <= sink_sum;
            end
          end
          ST_RETRACT: begin
            // The line end rests one tick at the top row before the hook respawns.
            if (cut_v_reg == TOP_ROW) begin
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
              cut_reg   <= 1'b0;
              v_reg     <= TOP_V;
              cut_v_reg <= TOP_ROW;
            end else if (retract_last) begin
              cut_v_reg <= TOP_ROW;
            end else begin
              cut_v_reg <= cut_v_reg - RETRACT_STEP;
            end
          end
          default: begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef HOOK_SWAY_EN
  logic signed [7:0] sway_reg;
  logic signed [7:0] sway_next;
  logic              sway_up_reg;
  logic              sway_up_next;
  logic              sway_run;
  logic [POS_W-1:0]  h_reg;

  // Sway only advances on ticks that leave the hook in HOLD or SINK.
  assign sway_run = tick_take &&
                    ((state_reg == ST_HOLD && !hook.reel_btn) ||
                     (state_reg == ST_SINK && !sink_last));

  always_comb begin
    sway_next    = sway_reg;
    sway_up_next = sway_up_reg;
    if (sway_run) begin
      if (sway_up_reg) begin
        if (sway_reg == SWAY_AMP) sway_up_next = 1'b0;
        else                      sway_next    = sway_reg + 8'sd1;
      end else begin
        if (sway_reg == -SWAY_AMP) sway_up_next = 1'b1;
        else                       sway_next    = sway_reg - 8'sd1;
      end
    end else if (tick_take) begin
      sway_next    = 8'sd0;
      sway_up_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sway_reg    <= 8'sd0;
      sway_up_reg <= 1'b1;
      h_reg       <= HOOK_X;
    end else begin
      sway_reg    <= sway_next;
      sway_up_reg <= sway_up_next;
      h_reg       <= HOOK_X + {{(POS_W-8){sway_next[7]}}, sway_next};
    end
  end

  assign hook.h_position = h_reg;
`else
  assign hook.h_position = HOOK_X;
`endif

  assign hook.v_position = v_reg;
  assign hook.cut        = cut_reg;
  assign hook.cut_v      = cut_v_reg;
  assign hook.busy       = busy_reg;
  assign hook.reel_done  = reel_done_reg;

endmodule
